// File: rtl/alu_cpu_pkg.sv
// alu_cpu_pkg: shared definitions for the parametrised accumulator CPU.
//   - opcode constants OP_CLR..OP_NOP (3-bit instruction field)
//   - FSM state encoding (state_t: ST_IDLE, ST_EXEC, ST_MULT)
//   - params_ok(): legality check for WIDTH / MUL_UNROLL
package alu_cpu_pkg;

  localparam logic [2:0] OP_CLR  = 3'd0;
  localparam logic [2:0] OP_SHR  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_INC  = 3'd3;
  localparam logic [2:0] OP_SWAP = 3'd4;
  localparam logic [2:0] OP_CMP  = 3'd5;
  localparam logic [2:0] OP_MUL  = 3'd6;
  localparam logic [2:0] OP_NOP  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MULT = 2'd2
  } state_t;

  // WIDTH must be even and >= 4; MUL_UNROLL in {1,2,4} and dividing WIDTH/2.
  function automatic bit params_ok(input int width, input int unroll);
    return (width >= 4) && ((width % 2) == 0) &&
           ((unroll == 1) || (unroll == 2) || (unroll == 4)) &&
           (((width / 2) % unroll) == 0);
  endfunction

endpackage

// File: rtl/alu_cpu_param_if.sv
// alu_cpu_param_if: host-side instruction/ready bus of the accumulator CPU.
//   data_in         operand for ADD / MUL (WIDTH bits)
//   instruction     3-bit opcode
//   new_instruction request strobe, qualified by ready
//   data_out        current accumulator value
//   ready           CPU idle and able to accept
//   carry, zero     status flags, present only with ALU_CPU_FLAGS_EN defined
// Modports: master = host sequencer, slave = CPU.
interface alu_cpu_param_if #(
  parameter int WIDTH = 16
);

  logic [WIDTH-1:0] data_in;
  logic [2:0]       instruction;
  logic             new_instruction;
  logic [WIDTH-1:0] data_out;
  logic             ready;
`ifdef ALU_CPU_FLAGS_EN
  logic             carry;
  logic             zero;
`endif

  modport master (
    output data_in,
    output instruction,
    output new_instruction,
`ifdef ALU_CPU_FLAGS_EN
    input  carry,
    input  zero,
`endif
    input  data_out,
    input  ready
  );

  modport slave (
    input  data_in,
    input  instruction,
    input  new_instruction,
`ifdef ALU_CPU_FLAGS_EN
    output carry,
    output zero,
`endif
    output data_out,
    output ready
  );

endinterface

// File: rtl/alu_cpu_mul.sv
// alu_cpu_mul: iterative shift-add multiplier, (WIDTH/2) x (WIDTH/2) -> WIDTH.
// Retires MUL_UNROLL multiplier bits per clock, so a product takes
// WIDTH/(2*MUL_UNROLL) iterations after start.
//   clk, rst  system clock, synchronous active-high reset
//   start     load operands a, b (iterations begin on the following edges)
//   a, b      unsigned half-width operands
//   done      high during the last iteration cycle; product is final then
//   product   running sum including the current iteration
module alu_cpu_mul
  import alu_cpu_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int MUL_UNROLL = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH/2-1:0] a,
  input  logic [WIDTH/2-1:0] b,
  output logic               done,
  output logic [WIDTH-1:0]   product
);

  localparam int HALF  = WIDTH / 2;
  localparam int ITERS = HALF / MUL_UNROLL;
  localparam int CW    = $clog2(ITERS + 1);

  if (!params_ok(WIDTH, MUL_UNROLL)) begin : g_param_check
    $error("alu_cpu_mul: WIDTH must be even and >= 4, MUL_UNROLL in {1,2,4} dividing WIDTH/2");
  end

  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] mcand_q;
  logic [HALF-1:0]  mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;

  // Partial products for the MUL_UNROLL low multiplier bits of this iteration.
  always_comb begin
    acc_d = acc_q;
    for (int i = 0; i < MUL_UNROLL; i++) begin
      if (mplier_q[i]) acc_d = acc_d + (mcand_q << i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (start) begin
      cnt_q    <= CW'(ITERS);
      mcand_q  <= {{HALF{1'b0}}, a};
      mplier_q <= b;
      acc_q    <= '0;
    end else if (cnt_q != '0) begin
      cnt_q    <= cnt_q - CW'(1);
      mcand_q  <= mcand_q << MUL_UNROLL;
      mplier_q <= mplier_q >> MUL_UNROLL;
      acc_q    <= acc_d;
    end
  end

  // Terminal count: the iteration in flight is the last one.
  assign done    = (cnt_q == CW'(1));
  assign product = acc_d;

endmodule

// File: rtl/alu_cpu_param.sv
// alu_cpu_param: parametrised single-accumulator CPU.
// A request is accepted when ready && new_instruction; single-cycle ops
// update AC one edge later, MUL runs WIDTH/(2*MUL_UNROLL) iterations in
// alu_cpu_mul and writes AC on its last edge. data_out always shows AC.
//   clk, rst  system clock, synchronous active-high reset
//   bus       alu_cpu_param_if slave (data_in, instruction, new_instruction,
//             data_out, ready; carry/zero with ALU_CPU_FLAGS_EN)
// Optional feature macro: ALU_CPU_FLAGS_EN (registered carry and zero flags).
//
// state   | meaning
// ST_IDLE | ready=1, waiting for new_instruction
// ST_EXEC | single-cycle op latched, AC written on the next edge
// ST_MULT | multiplier iterating, AC written on its last iteration
module alu_cpu_param
  import alu_cpu_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int MUL_UNROLL = 1
) (
  input  logic             clk,
  input  logic             rst,
  alu_cpu_param_if.slave   bus
);

  localparam int HALF = WIDTH / 2;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ac_q, ac_d;
  logic [WIDTH-1:0] operand_q;
  logic [2:0]       op_q;
  logic             ac_we;
  logic             accept;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;
  logic [WIDTH:0]   alu_out;   // {carry, result}

  assign bus.ready    = (state_q == ST_IDLE);
  assign bus.data_out = ac_q;
  assign accept       = bus.ready && bus.new_instruction;
  assign mul_start    = accept && (bus.instruction == OP_MUL);

  // Operands are taken straight off the bus at accept, so data_in may change afterwards.
  alu_cpu_mul #(
    .WIDTH      (WIDTH),
    .MUL_UNROLL (MUL_UNROLL)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (ac_q[HALF-1:0]),
    .b       (bus.data_in[HALF-1:0]),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    alu_out = {1'b0, ac_q};
    case (op_q)
      OP_CLR:  alu_out = '0;
      OP_SHR:  alu_out = {ac_q[0], 1'b0, ac_q[WIDTH-1:1]};
      OP_ADD:  alu_out = {1'b0, ac_q} + {1'b0, operand_q};
      OP_INC:  alu_out = {1'b0, ac_q} + {{WIDTH{1'b0}}, 1'b1};
      OP_SWAP: alu_out = {1'b0, ac_q[HALF-1:0], ac_q[WIDTH-1:HALF]};
      OP_CMP:  alu_out = {1'b0, ~ac_q};
      default: alu_out = {1'b0, ac_q};
    endcase
  end

  always_comb begin
    state_d = state_q;
    ac_we   = 1'b0;
    ac_d    = ac_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.new_instruction) begin
          state_d = (bus.instruction == OP_MUL) ? ST_MULT : ST_EXEC;
        end
      end
      ST_EXEC: begin
        ac_we   = 1'b1;
        ac_d    = alu_out[WIDTH-1:0];
        state_d = ST_IDLE;
      end
      ST_MULT: begin
        if (mul_done) begin
          ac_we   = 1'b1;
          ac_d    = mul_product;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ac_q      <= '0;
      op_q      <= OP_NOP;
      operand_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q      <= bus.instruction;
        operand_q <= bus.data_in;
      end
      if (ac_we) ac_q <= ac_d;
    end
  end

`ifdef ALU_CPU_FLAGS_EN
  logic carry_q;
  logic zero_q;

  // Only EXEC ops can produce a carry; a MUL write-back clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
    end else if (ac_we) begin
      carry_q <= (state_q == ST_EXEC) ? alu_out[WIDTH] : 1'b0;
      zero_q  <= (ac_d == '0);
    end
  end

  assign bus.carry = carry_q;
  assign bus.zero  = zero_q;
`else
  logic unused_alu_carry;
  assign unused_alu_carry = alu_out[WIDTH];
`endif

endmodule
